vending_machine_multi: RTL and testbench

Parametrised successor to the single-product vending controller. It supports a configurable number of products, a run-time-writable price table, and cycle-by-cycle coin accumulation with saturating credit. It also adds an inactivity timeout, a refund path and optional per-product stock tracking. It sits between the coin/payment front end and the dispense/change actuators; all outputs are registered.

---
 rtl/vending_machine_multi.sv | 181 ++++++++++++++++++
 tb/tb_vending_machine_multi.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_multi.sv
`default_nettype none
// ============================================================================
// Module   : vending_machine_multi
// Brief    : Multi-product vending controller with writable price table,
//            saturating coin credit, inactivity refund and optional stock
//            tracking (enabled by defining STOCK_TRACK_EN).
// Revision : 1.0 - initial release
// ============================================================================
module vending_machine_multi #(
    parameter int NUM_PRODUCTS = 8,
    parameter int CODE_W       = 3,
    parameter int VALUE_W      = 7,
    parameter int STOCK_W      = 4,
    parameter int INIT_STOCK   = 5,
    parameter int TIMEOUT_CYC  = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CODE_W-1:0]  product_code,
    input  logic               coin_valid,
    input  logic [VALUE_W-1:0] coin_value,
    input  logic               online_payment,
    input  logic               cancel,
    input  logic               price_we,
    input  logic [CODE_W-1:0]  price_addr,
    input  logic [VALUE_W-1:0] price_data,
    input  logic               restock,
    output logic [3:0]         state,
    output logic               dispense_product,
    output logic [VALUE_W-1:0] return_change,
    output logic [VALUE_W-1:0] product_price,
    output logic               sold_out,
    output logic [VALUE_W-1:0] credit
);

    localparam logic [3:0] c_st_idle     = 4'd0;
    localparam logic [3:0] c_st_select   = 4'd1;
    localparam logic [3:0] c_st_collect  = 4'd2;
    localparam logic [3:0] c_st_dispense = 4'd3;
    localparam logic [3:0] c_st_refund   = 4'd4;

    localparam int                c_tmr_w    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(TIMEOUT_CYC - 1);
    localparam logic [CODE_W:0]   c_num      = (CODE_W + 1)'(NUM_PRODUCTS);

    logic [3:0]         r_state, w_next_state;
    logic [CODE_W-1:0]  r_code;
    logic [VALUE_W-1:0] r_price [NUM_PRODUCTS];
    logic [VALUE_W-1:0] r_credit, r_product_price, r_return_change;
    logic               r_dispense, r_sold_out;
    logic [c_tmr_w-1:0] r_timer;

    logic [VALUE_W:0]   w_sum;
    logic [VALUE_W-1:0] w_next_credit;
    logic               w_code_valid, w_in_stock, w_sel_ok, w_paid, w_timeout;
    logic               w_in_idle;

    logic [VALUE_W-1:0] w_credit_d, w_price_d, w_change_d;
    logic               w_dispense_d, w_sold_out_d;
    logic [c_tmr_w-1:0] w_timer_d;

    assign w_in_idle     = (r_state == c_st_idle);
    assign w_sum         = {1'b0, r_credit} + {1'b0, (coin_valid ? coin_value : {VALUE_W{1'b0}})};
    assign w_next_credit = w_sum[VALUE_W] ? {VALUE_W{1'b1}} : w_sum[VALUE_W-1:0];
    assign w_code_valid  = ({1'b0, r_code} < c_num);
    assign w_paid        = (w_next_credit >= r_product_price);
    assign w_timeout     = (r_timer == c_tmr_last) && !coin_valid;
    assign w_sel_ok      = w_code_valid && w_in_stock;

`ifdef STOCK_TRACK_EN
    logic [STOCK_W-1:0] r_stock [NUM_PRODUCTS];

    assign w_in_stock = w_code_valid && (r_stock[r_code] != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PRODUCTS; i++) r_stock[i] <= STOCK_W'(INIT_STOCK);
        end else if (w_in_idle && restock) begin
            for (int i = 0; i < NUM_PRODUCTS; i++) r_stock[i] <= STOCK_W'(INIT_STOCK);
        end else if (r_state == c_st_dispense && r_stock[r_code] != '0) begin
            r_stock[r_code] <= r_stock[r_code] - STOCK_W'(1);
        end
    end
`else
    // Without stock storage every valid slot is always available.
    logic w_unused_restock;
    assign w_unused_restock = restock;
    assign w_in_stock       = 1'b1;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = c_st_idle;
        case (r_state)
            c_st_idle:    w_next_state = (start && !cancel) ? c_st_select : c_st_idle;
            c_st_select:  w_next_state = w_sel_ok ? c_st_collect : c_st_idle;
            c_st_collect: begin
                if (cancel)                      w_next_state = c_st_refund;
                else if (online_payment || w_paid) w_next_state = c_st_dispense;
                else if (w_timeout)              w_next_state = c_st_refund;
                else                             w_next_state = c_st_collect;
            end
            default:      w_next_state = c_st_idle;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        w_credit_d   = r_credit;
        w_price_d    = r_product_price;
        w_change_d   = '0;
        w_dispense_d = 1'b0;
        w_sold_out_d = 1'b0;
        w_timer_d    = r_timer;
        case (r_state)
            c_st_select: begin
                if (w_sel_ok) begin
                    w_price_d  = r_price[r_code];
                    w_credit_d = '0;
                    w_timer_d  = '0;
                end else begin
                    w_sold_out_d = 1'b1;
                end
            end
            c_st_collect: begin
                w_credit_d = w_next_credit;
                w_timer_d  = coin_valid ? '0 : r_timer + c_tmr_w'(1);
                if (w_next_state == c_st_dispense) begin
                    w_dispense_d = 1'b1;
                    w_change_d   = online_payment ? w_next_credit : w_next_credit - r_product_price;
                end else if (w_next_state == c_st_refund) begin
                    w_change_d = w_next_credit;
                end
            end
            default: ;
        endcase
        if (w_next_state == c_st_idle) begin
            w_credit_d = '0;
            w_price_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_credit        <= '0;
            r_product_price <= '0;
            r_return_change <= '0;
            r_dispense      <= 1'b0;
            r_sold_out      <= 1'b0;
            r_timer         <= '0;
            r_code          <= '0;
            for (int i = 0; i < NUM_PRODUCTS; i++) r_price[i] <= VALUE_W'(10 * (i + 1));
        end else begin
            r_credit        <= w_credit_d;
            r_product_price <= w_price_d;
            r_return_change <= w_change_d;
            r_dispense      <= w_dispense_d;
            r_sold_out      <= w_sold_out_d;
            r_timer         <= w_timer_d;
            if (w_in_idle && start && !cancel) r_code <= product_code;
            if (w_in_idle && price_we && ({1'b0, price_addr} < c_num))
                r_price[price_addr] <= price_data;
        end
    end

    assign state            = r_state;
    assign dispense_product = r_dispense;
    assign return_change    = r_return_change;
    assign product_price    = r_product_price;
    assign sold_out         = r_sold_out;
    assign credit           = r_credit;

endmodule
`default_nettype wire

// File: tb/tb_vending_machine_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_vending_machine_multi
// Brief    : Directed self-checking bench for vending_machine_multi
//            (six product slots so that codes 6 and 7 are invalid).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vending_machine_multi;

    localparam int NP = 6;

    logic       clk = 1'b0;
    logic       rst, start, coin_valid, online_payment, cancel, price_we, restock;
    logic [2:0] product_code, price_addr;
    logic [6:0] coin_value, price_data;
    logic [3:0] state;
    logic       dispense_product, sold_out;
    logic [6:0] return_change, product_price, credit;

    int n_vec = 0;
    int n_err = 0;

    vending_machine_multi #(
        .NUM_PRODUCTS(NP), .CODE_W(3), .VALUE_W(7), .STOCK_W(4),
        .INIT_STOCK(5), .TIMEOUT_CYC(255)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .product_code(product_code),
        .coin_valid(coin_valid), .coin_value(coin_value),
        .online_payment(online_payment), .cancel(cancel),
        .price_we(price_we), .price_addr(price_addr), .price_data(price_data),
        .restock(restock), .state(state), .dispense_product(dispense_product),
        .return_change(return_change), .product_price(product_price),
        .sold_out(sold_out), .credit(credit)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        rst = 0; start = 0; cancel = 0; coin_valid = 0; coin_value = 0;
        online_payment = 0; price_we = 0; price_addr = 0; price_data = 0;
        restock = 0; product_code = 0;
    endtask

    // Drives start for one edge then lets SELECT resolve; leaves inputs quiet.
    task automatic select(input logic [2:0] code);
        start = 1; product_code = code;
        tick();
        start = 0;
        tick();
    endtask

    task automatic test_reset();
        quiet();
        rst = 1;
        tick(); tick();
        rst = 0;
        n_vec++; if (state !== 4'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", state); end
        n_vec++; if ({dispense_product, sold_out, return_change, product_price, credit} !== 23'd0) begin
            n_err++; $display("FAIL rst_outputs: got %b want 0", {dispense_product, sold_out, return_change, product_price, credit});
        end
    endtask

    task automatic test_exact_coins();
        start = 1; product_code = 3'd1;
        tick();
        start = 0;
        n_vec++; if (state !== 4'd1) begin n_err++; $display("FAIL exact_select: got %0d want 1", state); end
        tick();
        n_vec++; if (state !== 4'd2 || product_price !== 7'd20) begin n_err++; $display("FAIL exact_collect: state %0d price %0d want 2/20", state, product_price); end
        coin_valid = 1; coin_value = 7'd10;
        tick();
        n_vec++; if (state !== 4'd2 || credit !== 7'd10) begin n_err++; $display("FAIL exact_credit: state %0d credit %0d want 2/10", state, credit); end
        tick();
        coin_valid = 0;
        n_vec++; if (state !== 4'd3 || dispense_product !== 1'b1 || return_change !== 7'd0 || credit !== 7'd20) begin
            n_err++; $display("FAIL exact_dispense: state %0d disp %b change %0d credit %0d want 3/1/0/20", state, dispense_product, return_change, credit);
        end
        tick();
        n_vec++; if (state !== 4'd0 || dispense_product !== 1'b0 || credit !== 7'd0 || product_price !== 7'd0) begin
            n_err++; $display("FAIL exact_idle: state %0d disp %b credit %0d price %0d want 0/0/0/0", state, dispense_product, credit, product_price);
        end
    endtask

    task automatic test_overpay();
        select(3'd4);
        coin_valid = 1; coin_value = 7'd70;
        tick();
        coin_valid = 0;
        n_vec++; if (state !== 4'd3 || dispense_product !== 1'b1 || return_change !== 7'd20) begin
            n_err++; $display("FAIL overpay: state %0d disp %b change %0d want 3/1/20", state, dispense_product, return_change);
        end
        tick();
        n_vec++; if (state !== 4'd0 || return_change !== 7'd0) begin n_err++; $display("FAIL overpay_idle: state %0d change %0d want 0/0", state, return_change); end
    endtask

    task automatic test_online();
        select(3'd2);
        coin_valid = 1; coin_value = 7'd10;
        tick();
        coin_valid = 0; online_payment = 1;
        tick();
        online_payment = 0;
        n_vec++; if (state !== 4'd3 || dispense_product !== 1'b1 || return_change !== 7'd10) begin
            n_err++; $display("FAIL online: state %0d disp %b change %0d want 3/1/10", state, dispense_product, return_change);
        end
        tick();
    endtask

    task automatic test_cancel();
        select(3'd4);
        coin_valid = 1; coin_value = 7'd50; cancel = 1;
        tick();
        coin_valid = 0; cancel = 0;
        n_vec++; if (state !== 4'd4 || dispense_product !== 1'b0 || return_change !== 7'd50) begin
            n_err++; $display("FAIL cancel_refund: state %0d disp %b change %0d want 4/0/50", state, dispense_product, return_change);
        end
        tick();
        n_vec++; if (state !== 4'd0) begin n_err++; $display("FAIL cancel_idle: got %0d want 0", state); end
        start = 1; cancel = 1; product_code = 3'd1;
        tick();
        start = 0; cancel = 0;
        n_vec++; if (state !== 4'd0) begin n_err++; $display("FAIL start_cancel: got %0d want 0", state); end
    endtask

    task automatic test_timeout();
        select(3'd0);
        for (int i = 0; i < 254; i++) tick();
        n_vec++; if (state !== 4'd2) begin n_err++; $display("FAIL timeout_early: got %0d want 2", state); end
        tick();
        n_vec++; if (state !== 4'd4 || return_change !== 7'd0 || dispense_product !== 1'b0) begin
            n_err++; $display("FAIL timeout_refund: state %0d change %0d disp %b want 4/0/0", state, return_change, dispense_product);
        end
        tick();
    endtask

    task automatic test_saturation();
        price_we = 1; price_addr = 3'd5; price_data = 7'd127;
        tick();
        price_we = 0;
        select(3'd5);
        coin_valid = 1; coin_value = 7'd100;
        tick();
        n_vec++; if (state !== 4'd2 || credit !== 7'd100) begin n_err++; $display("FAIL sat_partial: state %0d credit %0d want 2/100", state, credit); end
        tick();
        coin_valid = 0;
        n_vec++; if (state !== 4'd3 || credit !== 7'd127 || return_change !== 7'd0) begin
            n_err++; $display("FAIL sat_dispense: state %0d credit %0d change %0d want 3/127/0", state, credit, return_change);
        end
        tick();
    endtask

    task automatic test_stock();
        logic exp_ok;
        for (int i = 0; i < 6; i++) begin
`ifdef STOCK_TRACK_EN
            exp_ok = (i < 5);
`else
            exp_ok = 1'b1;
`endif
            select(3'd3);
            n_vec++; if (state !== (exp_ok ? 4'd2 : 4'd0) || sold_out !== !exp_ok) begin
                n_err++; $display("FAIL stock_buy%0d: state %0d sold_out %b want %0d/%b", i, state, sold_out, exp_ok ? 2 : 0, !exp_ok);
            end
            if (state == 4'd2) begin
                coin_valid = 1; coin_value = 7'd40;
                tick();
                coin_valid = 0;
                tick();
            end else begin
                tick();
            end
        end
        restock = 1;
        tick();
        restock = 0;
        select(3'd3);
        n_vec++; if (state !== 4'd2 || sold_out !== 1'b0) begin n_err++; $display("FAIL restock_buy: state %0d sold_out %b want 2/0", state, sold_out); end
        cancel = 1;
        tick();
        cancel = 0;
        tick();
    endtask

    task automatic test_price_write();
        price_we = 1; price_addr = 3'd0; price_data = 7'd7;
        tick();
        price_we = 0;
        select(3'd0);
        n_vec++; if (product_price !== 7'd7) begin n_err++; $display("FAIL pw_price: got %0d want 7", product_price); end
        coin_valid = 1; coin_value = 7'd10;
        tick();
        coin_valid = 0;
        n_vec++; if (state !== 4'd3 || return_change !== 7'd3) begin n_err++; $display("FAIL pw_change: state %0d change %0d want 3/3", state, return_change); end
        tick();
    endtask

    task automatic test_bad_code();
        start = 1; product_code = 3'd7;
        tick();
        start = 0;
        tick();
        n_vec++; if (state !== 4'd0 || sold_out !== 1'b1) begin n_err++; $display("FAIL bad_code: state %0d sold_out %b want 0/1", state, sold_out); end
        tick();
        n_vec++; if (sold_out !== 1'b0) begin n_err++; $display("FAIL bad_code_pulse: got %b want 0", sold_out); end
    endtask

    task automatic test_mid_reset();
        select(3'd2);
        coin_valid = 1; coin_value = 7'd10;
        tick();
        coin_valid = 0; rst = 1;
        tick();
        rst = 0;
        n_vec++; if (state !== 4'd0 || credit !== 7'd0 || return_change !== 7'd0 || product_price !== 7'd0) begin
            n_err++; $display("FAIL mid_reset: state %0d credit %0d change %0d price %0d want all 0", state, credit, return_change, product_price);
        end
    endtask

    initial begin
        test_reset();
        test_exact_coins();
        test_overpay();
        test_online();
        test_cancel();
        test_timeout();
        test_saturation();
        test_stock();
        test_price_write();
        test_bad_code();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
